// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/half/word accesses mapped onto a
// word-wide data memory, with read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } state_t;

    function automatic logic req_fault(input logic [1:0] size, input logic [ADDR_W-1:0] addr);
        logic f;
        case (size)
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = addr[0];
            SZ_WORD: f = (addr[1:0] != 2'b00);
            default: f = 1'b1;
        endcase
        return f | (addr[ADDR_W-1:MEM_AW+2] != {(ADDR_W-MEM_AW-2){1'b0}});
    endfunction

    // Little-endian lane extraction followed by sign/zero extension.
    function automatic logic [31:0] load_format(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: res = {{24{sgn & b[7]}}, b};
            SZ_HALF: res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: res[{off, 3'b000} +: 8]    = data[7:0];
            SZ_HALF: res[{off[1], 4'b0000} +: 16] = data[15:0];
            default: res = data;
        endcase
        return res;
    endfunction

    state_t            r_state, w_state;
    logic              r_we, w_we;
    logic [1:0]        r_size, w_size;
    logic              r_signed, w_signed;
    logic [1:0]        r_off, w_off;
    logic [MEM_AW-1:0] r_word_addr, w_word_addr;
    logic [31:0]       r_wdata, w_wdata;

    logic              r_req_ready, w_req_ready;
    logic              r_resp_valid, w_resp_valid;
    logic [31:0]       r_resp_data, w_resp_data;
    logic              r_resp_err, w_resp_err;
    logic              r_mem_en, w_mem_en;
    logic              r_mem_we, w_mem_we;
    logic [MEM_AW-1:0] r_mem_addr, w_mem_addr;
    logic [31:0]       r_mem_wdata, w_mem_wdata;

    logic              w_accept;
    logic              w_fault;
    logic [MEM_AW-1:0] w_req_word;
    logic [31:0]       w_merged;
    logic [31:0]       w_loaded;

    assign w_accept   = req_valid & r_req_ready;
    assign w_fault    = req_fault(req_size, req_addr);
    assign w_req_word = req_addr[MEM_AW+1:2];
    assign w_merged   = store_merge(mem_rdata, r_wdata, r_size, r_off);
    assign w_loaded   = load_format(mem_rdata, r_size, r_off, r_signed);

    // All outputs are computed for the next state here and registered below,
    // so every port is a flop that already reflects the state it belongs to.
    always_comb begin
        w_state      = r_state;
        w_we         = r_we;
        w_size       = r_size;
        w_signed     = r_signed;
        w_off        = r_off;
        w_word_addr  = r_word_addr;
        w_wdata      = r_wdata;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_data  = 32'h0000_0000;
        w_resp_err   = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = {MEM_AW{1'b0}};
        w_mem_wdata  = 32'h0000_0000;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_we        = req_we;
                    w_size      = req_size;
                    w_signed    = req_signed;
                    w_off       = req_addr[1:0];
                    w_word_addr = w_req_word;
                    w_wdata     = req_wdata;
                    if (w_fault) begin
                        w_state      = RESP;
                        w_resp_valid = 1'b1;
                        w_resp_err   = 1'b1;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        w_state     = WR;
                        w_mem_en    = 1'b1;
                        w_mem_we    = 1'b1;
                        w_mem_addr  = w_req_word;
                        w_mem_wdata = req_wdata;
                    end else begin
                        w_state    = RD;
                        w_mem_en   = 1'b1;
                        w_mem_addr = w_req_word;
                    end
                end else begin
                    w_state     = IDLE;
                    w_req_ready = 1'b1;
                end
            end
            RD: begin
                w_state = RD_DATA;
            end
            RD_DATA: begin
                if (r_we) begin
                    w_state     = WR;
                    w_mem_en    = 1'b1;
                    w_mem_we    = 1'b1;
                    w_mem_addr  = r_word_addr;
                    w_mem_wdata = w_merged;
                end else begin
                    w_state      = RESP;
                    w_resp_valid = 1'b1;
                    w_resp_data  = w_loaded;
                end
            end
            WR: begin
                w_state      = RESP;
                w_resp_valid = 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    w_state     = IDLE;
                    w_req_ready = 1'b1;
                end else begin
                    w_resp_valid = 1'b1;
                    w_resp_data  = r_resp_data;
                    w_resp_err   = r_resp_err;
                end
            end
            default: begin
                w_state     = IDLE;
                w_req_ready = 1'b1;
            end
        endcase
    end

    // State and captured request context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_off       <= 2'b00;
            r_word_addr <= {MEM_AW{1'b0}};
            r_wdata     <= 32'h0000_0000;
        end else begin
            r_state     <= w_state;
            r_we        <= w_we;
            r_size      <= w_size;
            r_signed    <= w_signed;
            r_off       <= w_off;
            r_word_addr <= w_word_addr;
            r_wdata     <= w_wdata;
        end
    end

    // Registered handshake and memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {MEM_AW{1'b0}};
            r_mem_wdata  <= 32'h0000_0000;
        end else begin
            r_req_ready  <= w_req_ready;
            r_resp_valid <= w_resp_valid;
            r_resp_data  <= w_resp_data;
            r_resp_err   <= w_resp_err;
            r_mem_en     <= w_mem_en;
            r_mem_we     <= w_mem_we;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases plus random traffic checked
// against a byte-level memory model; a separate monitor compares every response.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .MEM_AW(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          nmem;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [0:1023];
    logic [31:0] tb_mem  [0:1023];
    logic        mem_loaded = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    int          ncyc = 0;
    int          rr_mode = 2;
    logic [9:0]  cur_waddr = 10'd0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 8)       return 32'h0000_8000;
        else if (i == 12) return 32'h1122_3344;
        else              return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Data memory: one-cycle read latency, loaded with known contents at the first edge.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            if (mem_en && mem_we)  tb_mem[mem_addr] <= mem_wdata;
            if (mem_en && !mem_we) mem_rdata <= tb_mem[mem_addr];
        end
    end

    // Writeback back-pressure: random, forced low or forced high.
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       resp_ready = ($urandom_range(0, 3) != 0);
            1:       resp_ready = 1'b0;
            default: resp_ready = 1'b1;
        endcase
    end

    // Reference model: byte-addressed memory semantics, updates ref_mem when commit is set.
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic sgn,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input bit commit);
        exp_t        e;
        int          w;
        int          off;
        logic [31:0] word;
        logic [31:0] v;
        logic [31:0] mask;
        e.data = 32'h0; e.err = 1'b0; e.lat = 1; e.nmem = 0;
        if (size == 2'd3 || (size == 2'd1 && addr % 2 != 0) ||
            (size == 2'd2 && addr % 4 != 0) || addr >= 32'd4096) begin
            e.err = 1'b1;
            return e;
        end
        w    = int'(addr / 4);
        off  = int'(addr % 4);
        word = ref_mem[w];
        if (!we) begin
            e.lat = 3; e.nmem = 1;
            if (size == 2'd0) begin
                v = (word >> (8 * off)) & 32'hFF;
                if (sgn && v >= 32'd128) v = v - 32'd256;
            end else if (size == 2'd1) begin
                v = (word >> (8 * off)) & 32'hFFFF;
                if (sgn && v >= 32'd32768) v = v - 32'd65536;
            end else begin
                v = word;
            end
            e.data = v;
        end else if (size == 2'd2) begin
            e.lat = 2; e.nmem = 1;
            if (commit) ref_mem[w] = wdata;
        end else begin
            e.lat = 4; e.nmem = 2;
            mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
            if (commit) ref_mem[w] = (word & ~mask) | ((wdata << (8 * off)) & mask);
        end
        return e;
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit track);
        exp_t e;
        bit   ok;
        e = model(we, size, sgn, addr, wdata, track);
        if (track) exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        chk("accept", {31'b0, ok}, 32'd1);
        if (ok) cur_waddr = addr[11:2];
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && req_ready) begin done = 1'b1; break; end
        end
        chk("drain", {31'b0, done}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {27'b0, req_ready, resp_valid, resp_err, mem_en, mem_we}, 32'h10);
        chk({name, "_data"}, resp_data | mem_wdata | 32'(mem_addr), 32'h0);
    endtask

    int   accept_cyc = 0;
    int   mem_cnt = 0;
    bit   seen = 1'b0;
    bit   holding = 1'b0;
    bit   hs_prev = 1'b0;
    logic [31:0] hold_data;
    logic        hold_err;

    // Monitor: protocol checks every cycle, scoreboard pop on each response handshake.
    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            seen = 1'b0; holding = 1'b0; hs_prev = 1'b0; mem_cnt = 0;
        end else begin
            if (hs_prev) chk("ready_after_resp", {31'b0, req_ready}, 32'd1);
            hs_prev = 1'b0;
            if (!mem_en) begin
                chk("mem_idle_zero", mem_wdata | 32'(mem_addr), 32'h0);
            end else begin
                mem_cnt++;
                chk("mem_addr", 32'(mem_addr), 32'(cur_waddr));
                chk("mem_en_state", {30'b0, req_ready, resp_valid}, 32'h0);
            end
            if (holding) begin
                chk("stall_valid", {31'b0, resp_valid}, 32'd1);
                chk("stall_data", resp_data, hold_data);
                chk("stall_err", {31'b0, resp_err}, {31'b0, hold_err});
                holding = 1'b0;
            end
            if (resp_valid) begin
                chk("busy_not_ready", {31'b0, req_ready}, 32'd0);
                if (!seen) begin
                    seen = 1'b1;
                    chk("resp_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) chk("latency", 32'(ncyc - accept_cyc), 32'(exp_q[0].lat));
                end
                if (resp_ready) begin
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("resp_data", resp_data, mon_e.data);
                        chk("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
                        chk("mem_strobes", 32'(mem_cnt), 32'(mon_e.nmem));
                    end
                    seen = 1'b0; hs_prev = 1'b1; mem_cnt = 0;
                end else begin
                    holding = 1'b1; hold_data = resp_data; hold_err = resp_err;
                end
            end
            if (req_valid && req_ready) begin
                accept_cyc = ncyc;
                mem_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        int          bad;
        bit          ok;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_in");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset_out");

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 1'b1);
        issue(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 1'b1);
        issue(1'b1, 2'd1, 1'b0, 32'h32, 32'h1234_ABCD, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1);
        issue(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 1'b1);
        issue(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'h06, 32'hFFFF_FFFF, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b1);
        issue(1'b1, 2'd3, 1'b0, 32'h08, 32'h5555_5555, 1'b1);
        wait_idle();

        // Writeback stalls a load for five cycles; handshake lands on cycle 8.
        rr_mode = 1;
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin ok = 1'b1; break; end
        end
        chk("stall_resp_seen", {31'b0, ok}, 32'd1);
        repeat (4) @(negedge clk);
        rr_mode = 2;
        @(negedge clk);
        chk("stall_handshake", {30'b0, resp_valid, resp_ready}, 32'h3);
        @(negedge clk);
        chk("stall_ready_after", {31'b0, req_ready}, 32'd1);
        wait_idle();

        // Reset during RD_DATA of a byte store: no write, no response.
        issue(1'b1, 2'd0, 1'b0, 32'h25, 32'h0000_0077, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1'b1);
        issue(1'b1, 2'd0, 1'b0, 32'h26, 32'h0000_0099, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 1'b1);
        wait_idle();

        rr_mode = 0;
        repeat (250) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 63));
            else if (r == 7) a = 32'($urandom_range(0, 4095));
            else if (r == 8) a = 32'h1000 + 32'($urandom_range(0, 255));
            else             a = $urandom;
            r  = $urandom_range(0, 15);
            sz = (r == 15) ? 2'd3 : 2'(r % 3);
            if ($urandom_range(0, 1) == 1) a = a & ~((sz == 2'd2) ? 32'h3 : (sz == 2'd1) ? 32'h1 : 32'h0);
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        wait_idle();

        bad = 0;
        for (int i = 0; i < 1024; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
        chk("mem_contents", 32'(bad), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
